// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu : execute-stage integer ALU plus iterative RV32M multiply/divide unit.
//
// Base ALU ops complete one cycle after accept. M-extension ops run a radix-2
// shift-add multiplier or a restoring divider on operand magnitudes for XLEN
// iterations. Signs are applied on the final iteration, so the result is
// presented XLEN+1 cycles after accept.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   halt           freezes every register; forces in_ready low
//   in_valid       operands/op presented
//   in_ready       high in IDLE when not halted
//   m_op           1 = M op (funct3 selects), 0 = base op (op_val selects)
//   op_val         base op code
//   funct3         M op code
//   jump_instr     clear result[0] on write
//   operand_a/b    source operands
//   out_valid      one-cycle result pulse (stretched while halted)
//   result         registered result, held between pulses
//   busy           multiply/divide engine iterating
//   carry_flag     ADD carry-out / SUB borrow
//   overflow_flag  ADD/SUB signed overflow
//   zero_flag      written result is zero
// -----------------------------------------------------------------------------
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            m_op,
  input  logic [3:0]      op_val,
  input  logic [2:0]      funct3,
  input  logic            jump_instr,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            carry_flag,
  output logic            overflow_flag,
  output logic            zero_flag
);

  localparam int MSB = XLEN - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_REM    = 3'b110;

  // XLEN is a power of two, so the last iteration index is all ones.
  localparam logic [SHW-1:0] LAST_ITER = {SHW{1'b1}};
  localparam logic [SHW-1:0] ITER_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};

  // Jump targets must be halfword aligned: drop bit 0.
  function automatic logic [XLEN-1:0] clear_lsb(input logic jmp, input logic [XLEN-1:0] v);
    return {v[MSB:1], v[0] & ~jmp};
  endfunction

  // Two's-complement negate when requested.
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Registers
  logic [1:0]      state_r;
  logic [SHW-1:0]  iter_r;
  logic [XLEN-1:0] hi_r;       // product high half / partial remainder
  logic [XLEN-1:0] lo_r;       // multiplier bits / dividend bits becoming quotient
  logic [XLEN-1:0] opd_r;      // multiplicand magnitude / divisor magnitude
  logic [XLEN-1:0] a_r;        // original dividend for the divide-by-zero remainder
  logic [2:0]      f3_r;
  logic            neg_res_r;  // product or quotient must be negated
  logic            neg_rem_r;  // remainder takes dividend sign
  logic            div_zero_r;
  logic            jump_r;
  logic [XLEN-1:0] result_r;
  logic            out_valid_r;
  logic            carry_r;
  logic            ovf_r;
  logic            zero_r;

  // Combinational signals
  logic            accept_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN:0]   add_s;
  logic [XLEN:0]   sub_s;
  logic [XLEN-1:0] base_res_s;
  logic [XLEN-1:0] base_wr_s;
  logic            base_carry_s;
  logic            base_ovf_s;
  logic            base_ok_s;
  logic            a_sgn_s;
  logic            b_sgn_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic [XLEN:0]   mul_add_s;
  logic [XLEN-1:0] mul_hi_n_s;
  logic [XLEN-1:0] mul_lo_n_s;
  logic [2*XLEN-1:0] mul_fix_s;
  logic [XLEN-1:0] mul_wr_s;
  logic [XLEN:0]   div_shift_s;
  logic [XLEN:0]   div_trial_s;
  logic [XLEN-1:0] rem_n_s;
  logic [XLEN-1:0] quo_n_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] div_wr_s;

  assign in_ready      = (state_r == ST_IDLE) && !halt;
  assign accept_s      = in_valid && in_ready;
  assign busy          = (state_r == ST_MUL) || (state_r == ST_DIV);
  assign out_valid     = out_valid_r;
  assign result        = result_r;
  assign carry_flag    = carry_r;
  assign overflow_flag = ovf_r;
  assign zero_flag     = zero_r;

  assign shamt_s = operand_b[SHW-1:0];
  assign add_s   = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_s   = {1'b0, operand_a} - {1'b0, operand_b};

  // Single-cycle base ALU: result, carry/borrow and signed overflow.
  always_comb begin
    base_res_s   = ZERO_X;
    base_carry_s = 1'b0;
    base_ovf_s   = 1'b0;
    base_ok_s    = 1'b1;
    case (op_val)
      OP_ADD: begin
        base_res_s   = add_s[MSB:0];
        base_carry_s = add_s[XLEN];
        base_ovf_s   = (operand_a[MSB] == operand_b[MSB]) && (add_s[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        base_res_s   = sub_s[MSB:0];
        base_carry_s = sub_s[XLEN];  // borrow out == (a < b) unsigned
        base_ovf_s   = (operand_a[MSB] != operand_b[MSB]) && (sub_s[MSB] != operand_a[MSB]);
      end
      OP_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      OP_AND:  base_res_s = operand_a & operand_b;
      OP_OR:   base_res_s = operand_a | operand_b;
      OP_XOR:  base_res_s = operand_a ^ operand_b;
      OP_SLL:  base_res_s = operand_a << shamt_s;
      OP_SRL:  base_res_s = operand_a >> shamt_s;
      OP_SRA:  base_res_s = $unsigned($signed(operand_a) >>> shamt_s);
      default: base_ok_s  = 1'b0;
    endcase
  end

  assign base_wr_s = clear_lsb(jump_instr, base_res_s);

  // Operand signedness per M op; unsigned variants fall to the default.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
      end
      F3_MULHSU: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
  end

  assign a_neg_s = a_sgn_s & operand_a[MSB];
  assign b_neg_s = b_sgn_s & operand_b[MSB];
  assign mag_a_s = cond_neg(a_neg_s, operand_a);
  assign mag_b_s = cond_neg(b_neg_s, operand_b);

  // One shift-add multiply step: add multiplicand if the multiplier LSB is set,
  // then shift the {carry, hi, lo} product right by one.
  always_comb begin
    mul_add_s = {1'b0, hi_r};
    if (lo_r[0]) begin
      mul_add_s = {1'b0, hi_r} + {1'b0, opd_r};
    end else begin
      mul_add_s = {1'b0, hi_r};
    end
    {mul_hi_n_s, mul_lo_n_s} = {mul_add_s, lo_r[MSB:1]};
    mul_fix_s = neg_res_r ? -{mul_hi_n_s, mul_lo_n_s} : {mul_hi_n_s, mul_lo_n_s};
    if (f3_r == F3_MUL) begin
      mul_wr_s = clear_lsb(jump_r, mul_fix_s[MSB:0]);
    end else begin
      mul_wr_s = clear_lsb(jump_r, mul_fix_s[2*XLEN-1:XLEN]);
    end
  end

  // One restoring-divide step plus the sign/zero-divisor fixup of the final value.
  always_comb begin
    div_shift_s = {hi_r, lo_r[MSB]};
    div_trial_s = div_shift_s - {1'b0, opd_r};
    if (!div_trial_s[XLEN]) begin
      rem_n_s = div_trial_s[MSB:0];
      quo_n_s = {lo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_n_s = div_shift_s[MSB:0];
      quo_n_s = {lo_r[XLEN-2:0], 1'b0};
    end
    // MIN / -1 needs no special case: |MIN| / 1 with no sign flip yields MIN, rem 0.
    if (div_zero_r) begin
      quo_fix_s = ONES_X;
      rem_fix_s = a_r;
    end else begin
      quo_fix_s = cond_neg(neg_res_r, quo_n_s);
      rem_fix_s = cond_neg(neg_rem_r, rem_n_s);
    end
    if (f3_r[1]) begin
      div_wr_s = clear_lsb(jump_r, rem_fix_s);
    end else begin
      div_wr_s = clear_lsb(jump_r, quo_fix_s);
    end
  end

  // Control FSM, engine datapath and output registers; halt freezes all of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      iter_r      <= {SHW{1'b0}};
      hi_r        <= ZERO_X;
      lo_r        <= ZERO_X;
      opd_r       <= ZERO_X;
      a_r         <= ZERO_X;
      f3_r        <= 3'b000;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      jump_r      <= 1'b0;
      result_r    <= ZERO_X;
      out_valid_r <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (!halt) begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !m_op) begin
            result_r    <= base_wr_s;
            carry_r     <= base_carry_s;
            ovf_r       <= base_ovf_s;
            zero_r      <= base_ok_s && (base_wr_s == ZERO_X);
            out_valid_r <= 1'b1;
          end else if (accept_s) begin
            out_valid_r <= 1'b0;
            a_r         <= operand_a;
            f3_r        <= funct3;
            jump_r      <= jump_instr;
            iter_r      <= {SHW{1'b0}};
            hi_r        <= ZERO_X;
            neg_res_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r   <= a_neg_s;
            div_zero_r  <= (operand_b == ZERO_X);
            if (funct3[2]) begin
              state_r <= ST_DIV;
              lo_r    <= mag_a_s;
              opd_r   <= mag_b_s;
            end else begin
              state_r <= ST_MUL;
              lo_r    <= mag_b_s;
              opd_r   <= mag_a_s;
            end
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_MUL: begin
          hi_r   <= mul_hi_n_s;
          lo_r   <= mul_lo_n_s;
          iter_r <= iter_r + ITER_ONE;
          if (iter_r == LAST_ITER) begin
            result_r    <= mul_wr_s;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= (mul_wr_s == ZERO_X);
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_DIV: begin
          hi_r   <= rem_n_s;
          lo_r   <= quo_n_s;
          iter_r <= iter_r + ITER_ONE;
          if (iter_r == LAST_ITER) begin
            result_r    <= div_wr_s;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= (div_wr_s == ZERO_X);
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
